// File: rtl/uart_tx_core.sv
// 8N1 UART transmit core: free-running baud enables plus a byte serialiser.
// Also provides a 16x-oversample enable for a companion receiver.
module uart_tx_core #(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk_12m,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       tx,
  output logic       tx_busy,
  output logic       txclk_en,
  output logic       rxclk_en
);

  localparam int unsigned TxDivRaw = CLK_HZ / BAUD;
  localparam int unsigned RxDivRaw = CLK_HZ / (BAUD * 16);
  localparam int unsigned TX_DIV   = (TxDivRaw < 1) ? 1 : TxDivRaw;
  localparam int unsigned RX_DIV   = (RxDivRaw < 1) ? 1 : RxDivRaw;
  localparam int unsigned TxW      = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int unsigned RxW      = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;

  localparam logic [TxW-1:0] TxMax = TxW'(TX_DIV - 1);
  localparam logic [RxW-1:0] RxMax = RxW'(RX_DIV - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [TxW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RxW-1:0] rx_cnt_q, rx_cnt_d;
  logic [1:0]     state_q, state_d;
  logic [2:0]     bitpos_q, bitpos_d;
  logic [7:0]     data_q, data_d;
  logic           tx_q, tx_d;

  // Baud counters run regardless of transmitter state.
  always_comb begin
    tx_cnt_d = (tx_cnt_q == TxMax) ? '0 : tx_cnt_q + TxW'(1);
    rx_cnt_d = (rx_cnt_q == RxMax) ? '0 : rx_cnt_q + RxW'(1);
  end

  assign txclk_en = (tx_cnt_q == '0);
  assign rxclk_en = (rx_cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    bitpos_d = bitpos_q;
    data_d   = data_q;
    tx_d     = tx_q;
    case (state_q)
      StIdle: begin
        if (wr_en) begin
          data_d   = din;
          bitpos_d = 3'd0;
          state_d  = StStart;
        end
      end
      // Waiting for txclk_en here keeps the previous stop bit a full period.
      StStart: begin
        if (txclk_en) begin
          tx_d    = 1'b0;
          state_d = StData;
        end
      end
      StData: begin
        if (txclk_en) begin
          tx_d = data_q[bitpos_q];
          if (bitpos_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bitpos_d = bitpos_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (txclk_en) begin
          tx_d    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_12m) begin
    if (rst) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      state_q  <= StIdle;
      bitpos_q <= 3'd0;
      data_q   <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      state_q  <= state_d;
      bitpos_q <= bitpos_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed self-checking bench for uart_tx_core at the default 12 MHz / 115200 settings.
module tb_uart_tx_core;

  localparam int TxDiv = 104;
  localparam int RxDiv = 6;
  localparam int Frame = 1040;

  logic       clk_12m = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] din     = 8'h00;
  logic       wr_en   = 1'b0;
  logic       tx, tx_busy, txclk_en, rxclk_en;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;  // clocks since last reset release; tx_cnt model = cyc % TxDiv

  uart_tx_core dut (
    .clk_12m  (clk_12m),
    .rst      (rst),
    .din      (din),
    .wr_en    (wr_en),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .txclk_en (txclk_en),
    .rxclk_en (rxclk_en)
  );

  always #5 clk_12m = ~clk_12m;

  task automatic tick();
    @(posedge clk_12m);
    #1;
    cyc++;
  endtask

  // First sample carrying the start bit when acceptance happens at sample a.
  function automatic int start_sample(input int a);
    return ((a + TxDiv) / TxDiv) * TxDiv + 1;
  endfunction

  // Records one frame starting at sample s; ends on the last stop-bit sample.
  task automatic capture_frame(input int s, output logic [9:0] bits, output logic [9:0] busy,
                               output int unstable, output logic pre, output bit late);
    late = 1'b0;
    unstable = 0;
    bits = '0;
    busy = '0;
    pre = 1'bx;
    if (cyc > s - 1) begin
      late = 1'b1;
      return;
    end
    while (cyc < s - 1) tick();
    pre = tx;
    tick();
    for (int j = 0; j < 10; j++) begin
      bits[j] = tx;
      busy[j] = tx_busy;
      for (int i = 1; i < TxDiv; i++) begin
        tick();
        if (tx !== bits[j]) unstable++;
      end
      if (j < 9) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++;
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    n_checks++;
    if (txclk_en !== 1'b1) begin n_fail++; $display("FAIL reset_txclk_en: got %b expected 1", txclk_en); end
    n_checks++;
    if (rxclk_en !== 1'b1) begin n_fail++; $display("FAIL reset_rxclk_en: got %b expected 1", rxclk_en); end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_baud_gen();
    int tx_err = 0, rx_err = 0, line_err = 0, tx_pulses = 0, rx_pulses = 0;
    logic exp_tx, exp_rx;
    for (int i = 0; i < 2000; i++) begin
      exp_tx = (cyc % TxDiv == 0);
      exp_rx = (cyc % RxDiv == 0);
      if (txclk_en !== exp_tx) tx_err++;
      if (rxclk_en !== exp_rx) rx_err++;
      if (txclk_en === 1'b1) tx_pulses++;
      if (rxclk_en === 1'b1) rx_pulses++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) line_err++;
      if (i < 1999) tick();
    end
    n_checks++;
    if (tx_err != 0) begin n_fail++; $display("FAIL baud_tx_phase: got %0d bad cycles expected 0", tx_err); end
    n_checks++;
    if (rx_err != 0) begin n_fail++; $display("FAIL baud_rx_phase: got %0d bad cycles expected 0", rx_err); end
    n_checks++;
    if (tx_pulses != 20) begin n_fail++; $display("FAIL baud_tx_count: got %0d expected 20", tx_pulses); end
    n_checks++;
    if (rx_pulses != 334) begin n_fail++; $display("FAIL baud_rx_count: got %0d expected 334", rx_pulses); end
    n_checks++;
    if (line_err != 0) begin n_fail++; $display("FAIL idle_line: got %0d bad cycles expected 0", line_err); end
  endtask

  task automatic test_single_byte();
    int a, unst;
    logic [9:0] bits, busy;
    logic pre;
    bit late;
    // Accept one clock before a txclk_en: shortest start delay.
    while (cyc % TxDiv != TxDiv - 1) tick();
    din = 8'h48;
    wr_en = 1'b1;
    a = cyc;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise: got %b expected 1", tx_busy); end
    capture_frame(start_sample(a), bits, busy, unst, pre, late);
    n_checks++;
    if (late || pre !== 1'b1) begin n_fail++; $display("FAIL single_pre: got %b late %0d expected 1", pre, late); end
    n_checks++;
    if (bits !== 10'b1_0100_1000_0) begin
      n_fail++; $display("FAIL single_frame: got %b expected %b", bits, 10'b1_0100_1000_0);
    end
    n_checks++;
    if (unst != 0) begin n_fail++; $display("FAIL single_bit_width: got %0d glitches expected 0", unst); end
    n_checks++;
    if (busy !== 10'h1FF) begin n_fail++; $display("FAIL single_busy: got %b expected %b", busy, 10'h1FF); end
    tick();
    n_checks++;
    if (tx_busy !== 1'b0 || tx !== 1'b1) begin
      n_fail++; $display("FAIL single_idle_after: got busy %b tx %b expected busy 0 tx 1", tx_busy, tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                             8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    logic [9:0] fb [12];
    logic [9:0] bb [12];
    logic [9:0] exp;
    int un [12];
    logic pr [12];
    bit lt [12];
    int a, s0, k, guard, unst_sum, bad_busy, bad_pre;
    bit feed_to;
    repeat (37) tick();
    a = cyc;
    s0 = start_sample(a);
    k = 1;
    guard = 0;
    feed_to = 1'b0;
    din = msg[0];
    wr_en = 1'b1;
    fork
      begin
        while (guard < 20000) begin
          @(posedge clk_12m);
          #1;
          guard++;
          if (k == 12 && tx_busy === 1'b1) begin
            wr_en = 1'b0;
            break;
          end
          if (k < 12 && tx_busy === 1'b0) begin
            din = msg[k];
            k++;
          end
        end
        feed_to = (guard >= 20000);
      end
      begin
        for (int j = 0; j < 12; j++) capture_frame(s0 + Frame * j, fb[j], bb[j], un[j], pr[j], lt[j]);
      end
    join
    wr_en = 1'b0;
    unst_sum = 0;
    bad_busy = 0;
    bad_pre = 0;
    for (int j = 0; j < 12; j++) begin
      exp = {1'b1, msg[j], 1'b0};
      n_checks++;
      if (fb[j] !== exp) begin n_fail++; $display("FAIL b2b_frame%0d: got %b expected %b", j, fb[j], exp); end
      unst_sum += un[j];
      if (bb[j] !== 10'h1FF) bad_busy++;
      if (lt[j] || pr[j] !== 1'b1) bad_pre++;
    end
    n_checks++;
    if (unst_sum != 0) begin n_fail++; $display("FAIL b2b_bit_width: got %0d glitches expected 0", unst_sum); end
    n_checks++;
    if (bad_busy != 0) begin n_fail++; $display("FAIL b2b_busy: got %0d bad frames expected 0", bad_busy); end
    n_checks++;
    if (bad_pre != 0) begin n_fail++; $display("FAIL b2b_contiguous: got %0d bad frames expected 0", bad_pre); end
    n_checks++;
    if (feed_to) begin n_fail++; $display("FAIL b2b_feeder: got timeout expected 12 acceptances"); end
  endtask

  task automatic test_din_change();
    int a, unst, err;
    logic [9:0] bits, busy;
    logic pre;
    bit late;
    // Accept right on a txclk_en cycle: longest start delay.
    while (cyc % TxDiv != 0) tick();
    din = 8'h00;
    wr_en = 1'b1;
    a = cyc;
    tick();
    wr_en = 1'b0;
    din = 8'hFF;
    n_checks++;
    if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL din_busy_rise: got %b expected 1", tx_busy); end
    capture_frame(start_sample(a), bits, busy, unst, pre, late);
    n_checks++;
    if (late || pre !== 1'b1 || bits !== 10'b1_0000_0000_0 || unst != 0) begin
      n_fail++; $display("FAIL din_frozen_frame: got %b (glitches %0d) expected %b", bits, unst, 10'b1_0000_0000_0);
    end
    err = 0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (tx !== 1'b1 || tx_busy !== 1'b0) err++;
    end
    n_checks++;
    if (err != 0) begin n_fail++; $display("FAIL din_no_resend: got %0d active cycles expected 0", err); end
    wr_en = 1'b1;
    a = cyc;
    tick();
    wr_en = 1'b0;
    capture_frame(start_sample(a), bits, busy, unst, pre, late);
    n_checks++;
    if (late || bits !== 10'b1_1111_1111_0 || unst != 0) begin
      n_fail++; $display("FAIL din_reaccept: got %b (glitches %0d) expected %b", bits, unst, 10'b1_1111_1111_0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int a, s, unst;
    logic [9:0] bits, busy;
    logic pre;
    bit late;
    din = 8'hF0;
    wr_en = 1'b1;
    a = cyc;
    tick();
    wr_en = 1'b0;
    s = start_sample(a);
    while (cyc < s + 4 * TxDiv + 50) tick();
    n_checks++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_bit3: got tx %b busy %b expected tx 0 busy 1", tx, tx_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
    n_checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_line: got tx %b busy %b expected tx 1 busy 0", tx, tx_busy);
    end
    n_checks++;
    if (txclk_en !== 1'b1 || rxclk_en !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_counters: got txclk_en %b rxclk_en %b expected 1 1", txclk_en, rxclk_en);
    end
    repeat (300) tick();
    n_checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_aborted: got tx %b busy %b expected tx 1 busy 0", tx, tx_busy);
    end
    din = 8'hA5;
    wr_en = 1'b1;
    a = cyc;
    tick();
    wr_en = 1'b0;
    capture_frame(start_sample(a), bits, busy, unst, pre, late);
    n_checks++;
    if (late || pre !== 1'b1 || bits !== 10'b1_1010_0101_0 || unst != 0 || busy !== 10'h1FF) begin
      n_fail++; $display("FAIL rst_then_a5: got %b busy %b (glitches %0d) expected %b busy %b",
                         bits, busy, unst, 10'b1_1010_0101_0, 10'h1FF);
    end
  endtask

  task automatic test_rst_priority();
    int err;
    tick();
    rst = 1'b1;
    wr_en = 1'b1;
    din = 8'h81;
    tick();
    rst = 1'b0;
    wr_en = 1'b0;
    cyc = 0;
    n_checks++;
    if (tx_busy !== 1'b0 || tx !== 1'b1) begin
      n_fail++; $display("FAIL rst_prio_next: got busy %b tx %b expected busy 0 tx 1", tx_busy, tx);
    end
    err = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx !== 1'b1 || tx_busy !== 1'b0) err++;
    end
    n_checks++;
    if (err != 0) begin n_fail++; $display("FAIL rst_prio_idle: got %0d active cycles expected 0", err); end
  endtask

  initial begin
    test_reset();
    test_baud_gen();
    test_single_byte();
    test_back_to_back();
    test_din_change();
    test_reset_mid_frame();
    test_rst_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog");
  end

endmodule
